// File: rtl/winograd_input_loader.sv
// Stream-to-array loader for winograd_conv_10x12: collects a 9-word kernel and a
// 120-word image, launches the core, and keeps its operands frozen until it reports done.
module winograd_input_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [31:0] kernel_out [0:2][0:2],
    output logic [31:0] image_out  [0:9][0:11],
    output logic        conv_start,
    input  logic        conv_done,
    output logic        busy,
    output logic        frame_err,
    output logic [15:0] frame_count,
    output logic [2:0]  state_dbg
);

    // Handshake: a word moves on a rising edge where in_valid and in_ready are both high;
    // in_ready depends only on state, never on in_valid, and in_data/in_last are don't-care otherwise.
    typedef enum logic [2:0] {
        S_KERNEL = 3'd0,
        S_IMAGE  = 3'd1,
        S_START  = 3'd2,
        S_GUARD  = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  widx;
    logic [3:0]  r;
    logic [3:0]  c;
    logic        beat;
    logic        frame_end;

    assign beat      = in_valid & in_ready;
    assign frame_end = (widx == 8'd128);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_KERNEL;
            in_ready    <= 1'b1;
            conv_start  <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 16'd0;
            widx        <= 8'd0;
            r           <= 4'd0;
            c           <= 4'd0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    kernel_out[i][j] <= 32'd0;
            for (int i = 0; i < 10; i++)
                for (int j = 0; j < 12; j++)
                    image_out[i][j] <= 32'd0;
        end else begin
            conv_start <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_KERNEL, S_IMAGE: begin
                    if (beat) begin
                        if (widx < 8'd9) begin
                            for (int i = 0; i < 9; i++)
                                if (widx == 8'(i))
                                    kernel_out[i / 3][i % 3] <= in_data;
                        end else begin
                            image_out[r][c] <= in_data;
                            if (c == 4'd11) begin
                                c <= 4'd0;
                                r <= r + 4'd1;
                            end else begin
                                c <= c + 4'd1;
                            end
                        end
                        widx <= widx + 8'd1;
                        // A last flag anywhere but word 128, or its absence there, drops the frame.
                        if (in_last != frame_end) begin
                            frame_err <= 1'b1;
                            widx      <= 8'd0;
                            r         <= 4'd0;
                            c         <= 4'd0;
                            state     <= S_KERNEL;
                        end else if (frame_end) begin
                            conv_start <= 1'b1;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                            state      <= S_START;
                        end else if (widx == 8'd8) begin
                            state <= S_IMAGE;
                        end
                    end
                end
                S_START: begin
                    frame_count <= frame_count + 16'd1;
                    state       <= S_GUARD;
                end
                // The core may still be showing the previous job's done level here.
                S_GUARD: state <= S_WAIT;
                S_WAIT: begin
                    if (conv_done) begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        widx     <= 8'd0;
                        r        <= 4'd0;
                        c        <= 4'd0;
                        state    <= S_KERNEL;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_KERNEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_winograd_input_loader.sv
// Bench for winograd_input_loader: frames are driven word by word, good frames queue
// their expected array contents, and each conv_start pops and compares them.
module tb_winograd_input_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] kernel_out [0:2][0:2];
    logic [31:0] image_out  [0:9][0:11];
    logic        conv_start;
    logic        conv_done;
    logic        busy;
    logic        frame_err;
    logic [15:0] frame_count;
    logic [2:0]  state_dbg;

    winograd_input_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .kernel_out  (kernel_out),
        .image_out   (image_out),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .busy        (busy),
        .frame_err   (frame_err),
        .frame_count (frame_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] frame_w [0:128];
    int start_cnt     = 0;
    int err_cnt       = 0;
    int last_beat_cyc = 0;

    always @(negedge clk) begin
        if (conv_start || frame_err)
            check("start_err_exclusive", {31'd0, conv_start & frame_err}, 32'd0);
        if (conv_start) begin
            start_cnt++;
            check("start_latency", cyc - last_beat_cyc, 32'd0);
            check("start_expected", {31'd0, exp_q.size() >= 129}, 32'd1);
            if (exp_q.size() >= 129) begin
                for (int k = 0; k < 9; k++)
                    check("kernel_word", kernel_out[k / 3][k % 3], exp_q.pop_front());
                for (int k = 0; k < 120; k++)
                    check("image_word", image_out[k / 12][k % 12], exp_q.pop_front());
            end
        end
        if (frame_err) err_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic fill(input logic [31:0] base, input bit nominal);
        for (int i = 0; i < 129; i++) begin
            if (nominal) frame_w[i] = (i < 9) ? 32'(i + 1) : 32'(i - 8);
            else         frame_w[i] = base + 32'(i);
        end
    endtask

    task automatic push_expected();
        for (int i = 0; i < 129; i++) exp_q.push_back(frame_w[i]);
    endtask

    task automatic send_words(input int n, input int last_idx, input bit bubbly);
        int budget;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bubbly) begin
                while ($urandom_range(1, 0) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = frame_w[i];
            in_last  = (i == last_idx);
            budget   = 0;
            while (!in_ready && budget < 300) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                check("ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1 last_beat_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic done_pulse();
        @(negedge clk);
        check("busy_before_done", {31'd0, busy}, 32'd1);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        check("ready_after_done", {31'd0, in_ready}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int s0;
    int e0;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        conv_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_conv_start", {31'd0, conv_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        check("rst_kernel", kernel_out[2][2], 32'd0);
        check("rst_image", image_out[9][11], 32'd0);
        rst = 1'b0;

        // Nominal frame
        fill(32'd0, 1'b1);
        push_expected();
        send_words(129, 128, 1'b0);
        repeat (3) @(negedge clk);
        check("nom_starts", start_cnt, 32'd1);
        check("nom_frame_count", {16'd0, frame_count}, 32'd1);
        check("nom_kernel22", kernel_out[2][2], 32'd9);
        check("nom_image00", image_out[0][0], 32'd1);
        check("nom_image911", image_out[9][11], 32'd120);
        check("nom_ready_low", {31'd0, in_ready}, 32'd0);
        done_pulse();

        // Stale done held high across launch; guard must hold busy
        conv_done = 1'b1;
        fill(32'd1000, 1'b0);
        push_expected();
        send_words(129, 128, 1'b0);
        @(negedge clk);
        check("guard_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("wait_busy", {31'd0, busy}, 32'd1);
        conv_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'($urandom_range(1, 0));
            check("hold_busy", {31'd0, busy}, 32'd1);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("frozen_kernel00", kernel_out[0][0], 32'd1000);
        check("frozen_image00", image_out[0][0], 32'd1009);
        check("frozen_image911", image_out[9][11], 32'd1128);
        conv_done = 1'b1;
        check("ready_before_redone", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        conv_done = 1'b0;
        check("ready_at_redone", {31'd0, in_ready}, 32'd1);
        check("guard_starts", start_cnt, 32'd2);
        check("guard_frame_count", {16'd0, frame_count}, 32'd2);

        // Early in_last on word 50, then a good frame
        s0 = start_cnt;
        e0 = err_cnt;
        fill(32'd2000, 1'b0);
        send_words(51, 50, 1'b0);
        repeat (2) @(negedge clk);
        check("early_err", err_cnt, e0 + 1);
        check("early_no_start", start_cnt, s0);
        check("early_frame_count", {16'd0, frame_count}, 32'd2);
        check("early_ready", {31'd0, in_ready}, 32'd1);
        fill(32'd3000, 1'b0);
        push_expected();
        send_words(129, 128, 1'b0);
        repeat (2) @(negedge clk);
        check("after_err_image00", image_out[0][0], 32'd3009);
        check("after_err_frame_count", {16'd0, frame_count}, 32'd3);
        done_pulse();

        // Missing in_last on word 128
        s0 = start_cnt;
        e0 = err_cnt;
        fill(32'd4000, 1'b0);
        send_words(129, -1, 1'b0);
        repeat (2) @(negedge clk);
        check("nolast_err", err_cnt, e0 + 1);
        check("nolast_no_start", start_cnt, s0);
        check("nolast_image911", image_out[9][11], 32'd4128);
        check("nolast_frame_count", {16'd0, frame_count}, 32'd3);
        check("nolast_ready", {31'd0, in_ready}, 32'd1);

        // Bubbly valid with nominal data
        fill(32'd0, 1'b1);
        push_expected();
        send_words(129, 128, 1'b1);
        repeat (2) @(negedge clk);
        check("bubbly_frame_count", {16'd0, frame_count}, 32'd4);
        done_pulse();

        // Reset after word 70
        s0 = start_cnt;
        e0 = err_cnt;
        fill(32'd5000, 1'b0);
        send_words(71, -1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_start", {31'd0, conv_start}, 32'd0);
        check("midrst_err", {31'd0, frame_err}, 32'd0);
        check("midrst_frame_count", {16'd0, frame_count}, 32'd0);
        check("midrst_kernel11", kernel_out[1][1], 32'd0);
        check("midrst_image00", image_out[0][0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_pulses", (start_cnt - s0) + (err_cnt - e0), 32'd0);
        fill(32'd0, 1'b1);
        push_expected();
        send_words(129, 128, 1'b0);
        repeat (2) @(negedge clk);
        check("post_rst_frame_count", {16'd0, frame_count}, 32'd1);
        check("post_rst_image911", image_out[9][11], 32'd120);
        done_pulse();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/winograd_input_loader.md
# winograd_input_loader

Upstream feeder for `winograd_conv_10x12`. It accepts one convolution job as a valid/ready word stream: 9 kernel words, then 120 image words, both row-major. It assembles the stream into the `kernel_out[0:2][0:2]` and `image_out[0:9][0:11]` arrays, pulses `conv_start`, and holds the arrays stable until the core reports `conv_done`. Frames with bad length are dropped and flagged.

## Interface
- No parameters. Geometry is fixed: kernel 3x3, image 10x12, 32-bit words, 129 words per frame.
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  stream word present.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  32  stream word, passed through unmodified.
- `in_last`  in  1  marks the final word of a frame.
- `kernel_out[0:2][0:2]`  out  32 each  connects to the core's `kernel_in`.
- `image_out[0:9][0:11]`  out  32 each  connects to the core's `image_in`.
- `conv_start`  out  1  one-cycle start pulse to the core.
- `conv_done`  in  1  level done from the core.
- `busy`  out  1  high in S_START, S_GUARD and S_WAIT.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped.
- `frame_count`  out  16  count of frames launched to the core; wraps modulo 2^16.

## Operation
- A beat is a rising edge with `in_valid & in_ready`. The word index `widx` (8-bit) counts from 0 to 128.
- Word placement:
  - `widx` 0..8 goes to `kernel_out[widx/3][widx%3]`.
  - `widx` 9..128 goes to `image_out[r][c]`.
  - `r` and `c` are separate counters. `c` wraps at 11 and then increments `r`. No divider is used.
- State machine:
  - **S_KERNEL**
    - `in_ready`=1.
    - The beat at `widx`=8 moves to S_IMAGE.
  - **S_IMAGE**
    - `in_ready`=1.
    - The beat at `widx`=128 with `in_last`=1 moves to S_START.
  - **S_START**
    - `conv_start`=1 and `in_ready`=0.
    - `frame_count` increments.
    - Always moves to S_GUARD.
  - **S_GUARD**
    - One cycle. `conv_done` is ignored here, because the core's done can still show the previous job's level.
    - Moves to S_WAIT.
  - **S_WAIT**
    - `in_ready`=0.
    - `conv_done`=1 moves to S_KERNEL. `widx`, `r` and `c` are cleared.
- Framing errors:
  - `in_last`=1 on a beat with `widx`<128 drops the frame.
  - `in_last`=0 on the beat with `widx`=128 drops the frame.
  - On either drop: the offending word is still written, `frame_err` pulses on the next cycle, all indices clear, and the state returns to S_KERNEL. No start is issued and `frame_count` is unchanged.
- Output arrays are never cleared except by reset. A dropped frame leaves partially overwritten contents.
- The arrays are written only in S_KERNEL and S_IMAGE. Core operands are therefore frozen from S_START until `conv_done`.

## Timing
- Reset values:
  - State S_KERNEL, so `in_ready`=1 immediately after reset.
  - `conv_start`=0, `busy`=0, `frame_err`=0, `frame_count`=0.
  - All array elements 0; `widx`, `r`, `c` all 0.
- Reset asserted mid-frame or mid-wait aborts at once. No `conv_start` or `frame_err` is emitted.
- An array element is updated at the edge of its beat and is visible the next cycle.
- Launch latency:
  - Last beat accepted at edge N.
  - `conv_start` is high in cycle N..N+1 (registered, exactly one cycle).
  - S_GUARD is cycle N+1..N+2.
  - `conv_done` is first sampled at edge N+3.
- Return latency: `conv_done` sampled high at edge M means `in_ready`=1 from edge M onward. The next frame's first word can be accepted at edge M+1.
- Throughput:
  - One word per cycle during loading.
  - Minimum frame period is 129 + 2 + core latency + 1 cycles.
- `in_valid` may toggle freely. Only the beat condition advances `widx`.
- `in_data` and `in_last` are ignored whenever `in_ready`=0.
- `frame_err` and `conv_start` are never high in the same cycle.

## Test plan
- **Nominal frame.** Stream kernel 1..9, then image values i*12+j+1, with `in_last` on word 128.
  - `kernel_out[2][2]`=9, `image_out[0][0]`=1, `image_out[9][11]`=120.
  - Exactly one `conv_start` pulse, one cycle after the last beat.
  - `frame_count`=1.
- **Backpressure and guard.** Hold the stub `conv_done`=1 continuously. Then, 20 cycles after start, drop it and re-raise it for one cycle.
  - `busy` stays high through S_GUARD; the stale done is ignored.
  - `in_ready` returns exactly at the sampled re-raise.
  - Words presented while `in_ready`=0 leave the arrays unchanged.
- **Early `in_last`.** Assert it on word 50.
  - One `frame_err` pulse, no `conv_start`, `frame_count` unchanged.
  - The next full frame launches normally, with `image_out[0][0]` equal to that frame's word 9.
- **Missing `in_last`.** Send word 128 with `in_last`=0.
  - `frame_err` pulses, no `conv_start`.
  - `image_out[9][11]` holds the value of word 128.
- **Bubbly valid.** Random `in_valid` gaps at about 50% duty cycle, with the nominal data.
  - Identical array contents to the nominal case.
  - Start occurs one cycle after the last accepted beat.
- **Reset mid-frame.** Assert `rst` after word 70 for 2 cycles.
  - All outputs at reset values.
  - A subsequent nominal frame gives `frame_count`=1 and correct arrays.
